// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        valid;
  } if_id_t;

  localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/fetch_ctrl_if_id_reg.sv
// IF/ID pipeline register: a flush beats a stall, and with nothing to load it takes a bubble.
// A flush or a bubble leaves the PC fields unchanged and only kills valid/instr.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        load_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pcplus4_o,
  output logic        valid_o
);

  if_id_t q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q.instr   <= NOP_INSTR;
      q_q.pc      <= 32'd0;
      q_q.pcplus4 <= 32'd0;
      q_q.valid   <= 1'b0;
    end else if (flush_i) begin
      q_q.instr <= NOP_INSTR;
      q_q.valid <= 1'b0;
    end else if (!stall_i) begin
      if (load_i) begin
        q_q.instr   <= instr_i;
        q_q.pc      <= pc_i;
        q_q.pcplus4 <= pc_i + PC_INCR;
        q_q.valid   <= 1'b1;
      end else begin
        q_q.instr <= NOP_INSTR;
        q_q.valid <= 1'b0;
      end
    end
  end

  assign instr_o   = q_q.instr;
  assign pc_o      = q_q.pc;
  assign pcplus4_o = q_q.pcplus4;
  assign valid_o   = q_q.valid;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: one imem request per PC, variable-latency ack, one-entry stall buffer,
// wrong-path drain on redirect, and a sticky timeout flag for a memory that never answers.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_f,
  output logic        pc_hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic        stall_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
  output logic        fetch_err
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYC);

  fetch_state_t state_q;
  logic [31:0]  drain_addr_q;
  logic [31:0]  buf_instr_q;
  logic [31:0]  buf_pc_q;
  logic [15:0]  tmo_cnt_q;
  logic         fetch_err_q;

  logic         waiting;
  logic         ld_vld;
  logic [31:0]  ld_instr;
  logic [31:0]  ld_pc;

  assign waiting   = ((state_q == REQ) || (state_q == DRAIN)) && !imem_ack;
  assign imem_req  = (state_q == REQ) || (state_q == DRAIN);
  assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_f;
  assign fetch_err = fetch_err_q;

  // PC advances only when the current word is consumed or a redirect target must be loaded.
  always_comb begin
    pc_hold = 1'b1;
    case (state_q)
      REQ:     if (redirect || (imem_ack && !stall_d)) pc_hold = 1'b0;
      HOLD:    if (redirect || !stall_d) pc_hold = 1'b0;
      DRAIN:   if (redirect) pc_hold = 1'b0;
      default: pc_hold = 1'b1;
    endcase
  end

  always_comb begin
    ld_vld   = 1'b0;
    ld_instr = imem_rdata;
    ld_pc    = pc_f;
    if (state_q == REQ) begin
      ld_vld = imem_ack;
    end else if (state_q == HOLD) begin
      ld_vld   = 1'b1;
      ld_instr = buf_instr_q;
      ld_pc    = buf_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      drain_addr_q <= 32'd0;
      buf_instr_q  <= NOP_INSTR;
      buf_pc_q     <= 32'd0;
      tmo_cnt_q    <= 16'd0;
      fetch_err_q  <= 1'b0;
    end else begin
      if (waiting) begin
        if (tmo_cnt_q != TMO_LIMIT) begin
          tmo_cnt_q <= tmo_cnt_q + 16'd1;
          if (tmo_cnt_q + 16'd1 == TMO_LIMIT) fetch_err_q <= 1'b1;
        end
      end else begin
        tmo_cnt_q <= 16'd0;
      end

      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (redirect && !imem_ack) begin
            drain_addr_q <= pc_f;
            state_q      <= DRAIN;
          end else if (!redirect && imem_ack && stall_d) begin
            buf_instr_q <= imem_rdata;
            buf_pc_q    <= pc_f;
            state_q     <= HOLD;
          end
        end
        HOLD:    if (redirect || !stall_d) state_q <= REQ;
        DRAIN:   if (imem_ack) state_q <= REQ;
        default: state_q <= IDLE;
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (redirect),
    .stall_i  (stall_d),
    .load_i   (ld_vld),
    .instr_i  (ld_instr),
    .pc_i     (ld_pc),
    .instr_o  (instr_d),
    .pc_o     (pc_d),
    .pcplus4_o(pcplus4_d),
    .valid_o  (valid_d)
  );

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch-stage controller between the PC register and instruction memory, driving the IF/ID pipeline register.
- Issues a request per PC value and waits for a variable-latency acknowledge.
- Drives the PC hold (active-low enable) signal, absorbs decode stalls in a one-entry buffer, and drops wrong-path fetches on redirect.

Parameters:
- NOP_INSTR, 32'h0000_0000, instruction word presented to decode for bubbles and flushes.
- TIMEOUT_CYC, 255, consecutive un-acked wait cycles before fetch_err sets; range 1..65535.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_f  in  32  current PC from the PC register.
- pc_hold  out  1  to the PC register enable: 1 = hold PC, 0 = load next PC.
- imem_req  out  1  instruction memory request.
- imem_addr  out  32  request address.
- imem_ack  in  1  memory response valid; imem_rdata is valid this cycle.
- imem_rdata  in  32  fetched instruction.
- redirect  in  1  branch/jump taken from execute; flush fetch and let the PC load its target.
- stall_d  in  1  decode stalled; IF/ID must hold.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pcplus4_d  out  32  IF/ID PC+4.
- valid_d  out  1  IF/ID valid.
- fetch_err  out  1  sticky memory timeout flag.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; valid_d=0, instr_d=NOP_INSTR, pc_d=0, pcplus4_d=0, fetch_err=0.
  - Timeout counter cleared, drain address cleared, buffer empty.
  - pc_hold=1, imem_req=0.
- States:
  - IDLE goes unconditionally to REQ on the first edge after reset release.
  - REQ: imem_req=1, imem_addr=pc_f (the PC is held stable by pc_hold=1).
  - HOLD: instruction buffered, imem_req=0.
  - DRAIN: imem_req=1, imem_addr=drain_addr.
- pc_hold is combinational (Mealy). It is 0 only when one of these holds; otherwise it is 1:
  - REQ & imem_ack & !stall_d, or
  - HOLD & !stall_d, or
  - redirect=1 in REQ, HOLD or DRAIN.
- Redirect while an outstanding request is pending in DRAIN: pc_hold=0 so the PC loads the new target. Stay in DRAIN until ack.
- REQ transitions, priority order:
  - redirect & imem_ack: discard data, stay REQ.
  - redirect & !imem_ack: drain_addr<=pc_f, go to DRAIN.
  - imem_ack & !stall_d: IF/ID <= {rdata, pc_f, pc_f+4, valid=1}, stay REQ. Back-to-back throughput is one instruction per ack.
  - imem_ack & stall_d: buf <= {rdata, pc_f}, go to HOLD.
  - Otherwise stay REQ.
- HOLD transitions:
  - redirect: drop buffer, go to REQ.
  - !stall_d: IF/ID <= buffer contents with valid=1, go to REQ.
  - Otherwise stay HOLD.
- DRAIN: on imem_ack, discard data and go to REQ. redirect has no further state effect.
- IF/ID update rules, per edge:
  - redirect has highest priority: valid_d<=0, instr_d<=NOP_INSTR (overrides stall_d).
  - Else if stall_d: hold all IF/ID outputs.
  - Else load the captured instruction if one exists this cycle, otherwise a bubble (valid_d=0, instr_d=NOP_INSTR, pc fields unchanged).
- Arithmetic: pcplus4_d = pc+32'd4, modulo 2^32 (0xFFFF_FFFC yields 0x0000_0000).
- Timeout:
  - Counter increments each cycle in REQ/DRAIN with imem_ack=0.
  - Clears on ack or on leaving those states.
  - Saturates at TIMEOUT_CYC; at TIMEOUT_CYC, fetch_err<=1, sticky until reset.
  - The FSM keeps waiting after the flag sets.
- Reset mid-request: all state clears immediately. A late ack after reset release while in IDLE is ignored.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum {IDLE, REQ, HOLD, DRAIN}.
  - if_id_t struct {instr, pc, pcplus4, valid}.
  - Constant PC_INCR=32'd4.
- One sub-module, if_id_reg: the IF/ID register with flush-over-stall priority and the NOP_INSTR parameter.
- The FSM, buffer and timeout counter stay in fetch_ctrl.

Test Plan:
- Single-cycle memory (ack every REQ cycle), pc_f stepping 0x0,0x4,0x8:
  - valid_d=1 every cycle after the first request.
  - pc_d=0x0,0x4,0x8; pcplus4_d=0x4,0x8,0xC; pc_hold=0 each ack cycle.
- Ack 3 cycles late at pc_f=0x100, rdata=0xE3A00001:
  - pc_hold=1 and imem_req=1 for 3 cycles; valid_d=0 bubbles.
  - Then instr_d=0xE3A00001, pc_d=0x100.
- Ack at pc_f=0x20 with stall_d=1 for 2 cycles:
  - State HOLD, imem_req=0, IF/ID unchanged.
  - On stall release: instr_d=buffered word, pc_d=0x20, pc_hold=0 for one cycle.
- redirect at pc_f=0x40 with no ack:
  - valid_d=0, instr_d=NOP_INSTR, pc_hold=0.
  - Next cycles: imem_addr=0x40 (DRAIN) until ack, then imem_addr=new pc_f (e.g. 0x200); ack data from 0x40 never reaches valid_d.
- Simultaneous redirect+ack+stall_d=1: data dropped, valid_d=0, state stays REQ.
- TIMEOUT_CYC=4, no ack:
  - fetch_err=1 after 4 wait cycles, stays 1 after a later ack.
  - Clears only after rst_n low; rst_n low mid-REQ forces imem_req=0 and pc_hold=1 immediately.
